// File: rtl/seg7_display_scheduler_if.sv
// Request-side handshake bundle for the seven-segment display scheduler.
// Requesters post a level valid plus a signed byte and receive a one-cycle ack.
interface seg7_display_scheduler_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_val;
  logic [NUM_REQ-1:0]   req_ack;

  modport master (
    output req_valid,
    output req_val,
    input  req_ack
  );

  modport slave (
    input  req_valid,
    input  req_val,
    output req_ack
  );
endinterface

// File: rtl/seg7_display_scheduler.sv
// Round-robin display scheduler: grants one requester, converts its signed
// byte to sign + 3 BCD digits by shift-add-3, then holds it for a dwell time.
module seg7_display_scheduler #(
  parameter int NUM_REQ      = 3,
  parameter int DWELL_CYCLES = 50000000,
  parameter int CNT_W        = 26
) (
  input  logic                    clk,
  input  logic                    rst,
  seg7_display_scheduler_if.slave bus,
  output logic                    disp_neg,
  output logic [3:0]              disp_dig0,
  output logic [3:0]              disp_dig1,
  output logic [3:0]              disp_dig2,
  output logic [1:0]              disp_src,
  output logic                    disp_valid
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DWELL   = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CYCLES - 1);

  state_e             state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               neg_q, neg_d;
  logic [1:0]         src_q, src_d;
  logic [7:0]         mag_q, mag_d;
  logic [11:0]        bcd_q, bcd_d;
  logic [3:0]         bit_q, bit_d;
  logic [CNT_W-1:0]   dwell_q, dwell_d;
  logic               dneg_q, dneg_d;
  logic [11:0]        dig_q, dig_d;
  logic [1:0]         dsrc_q, dsrc_d;
  logic               dvalid_q, dvalid_d;

  logic               grant_hit;
  logic [1:0]         grant_idx;
  logic [7:0]         sel_val;
  logic [11:0]        bcd_adj;

  // Search starts just past the last winner so nobody starves.
  always_comb begin : arb
    int idx;
    grant_hit = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!grant_hit && bus.req_valid[idx]) begin
        grant_hit = 1'b1;
        grant_idx = 2'(idx);
      end
    end
  end

  assign sel_val = bus.req_val[{grant_idx, 3'b000} +: 8];

  always_comb begin
    bcd_adj = '0;
    for (int n = 0; n < 3; n++) begin
      if (bcd_q[4*n +: 4] >= 4'd5)
        bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
      else
        bcd_adj[4*n +: 4] = bcd_q[4*n +: 4];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      ptr_q    <= 2'(NUM_REQ - 1);
      ack_q    <= '0;
      neg_q    <= 1'b0;
      src_q    <= '0;
      mag_q    <= '0;
      bcd_q    <= '0;
      bit_q    <= '0;
      dwell_q  <= '0;
      dneg_q   <= 1'b0;
      dig_q    <= '0;
      dsrc_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      ack_q    <= ack_d;
      neg_q    <= neg_d;
      src_q    <= src_d;
      mag_q    <= mag_d;
      bcd_q    <= bcd_d;
      bit_q    <= bit_d;
      dwell_q  <= dwell_d;
      dneg_q   <= dneg_d;
      dig_q    <= dig_d;
      dsrc_q   <= dsrc_d;
      dvalid_q <= dvalid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    ack_d    = '0;
    neg_d    = neg_q;
    src_d    = src_q;
    mag_d    = mag_q;
    bcd_d    = bcd_q;
    bit_d    = bit_q;
    dwell_d  = dwell_q;
    dneg_d   = dneg_q;
    dig_d    = dig_q;
    dsrc_d   = dsrc_q;
    dvalid_d = dvalid_q;
    unique case (state_q)
      IDLE: begin
        if (grant_hit) begin
          state_d          = CONVERT;
          ptr_d            = grant_idx;
          ack_d[grant_idx] = 1'b1;
          src_d            = grant_idx;
          neg_d            = sel_val[7];
          mag_d            = sel_val[7] ? (~sel_val + 8'd1) : sel_val;
          bcd_d            = '0;
          bit_d            = '0;
        end
      end
      CONVERT: begin
        // Eight shift steps, then one commit edge updating all fields at once.
        if (bit_q == 4'd8) begin
          state_d  = DWELL;
          dneg_d   = neg_q;
          dig_d    = bcd_q;
          dsrc_d   = src_q;
          dvalid_d = 1'b1;
          dwell_d  = '0;
        end else begin
          {bcd_d, mag_d} = {bcd_adj, mag_q} << 1;
          bit_d          = bit_q + 4'd1;
        end
      end
      DWELL: begin
        if (dwell_q == LAST)
          state_d = IDLE;
        else
          dwell_d = dwell_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ack = ack_q;
    disp_neg    = dneg_q;
    disp_dig2   = dig_q[11:8];
    disp_dig1   = dig_q[7:4];
    disp_dig0   = dig_q[3:0];
    disp_src    = dsrc_q;
    disp_valid  = dvalid_q;
  end

endmodule

// File: tb/tb_seg7_display_scheduler.sv
// Directed bench for seg7_display_scheduler with a short dwell time.
// Checks conversion values, commit latency, round-robin order and reset abort.
module tb_seg7_display_scheduler;

  localparam int NR = 3;

  logic       clk;
  logic       rst;
  logic       disp_neg;
  logic [3:0] disp_dig0;
  logic [3:0] disp_dig1;
  logic [3:0] disp_dig2;
  logic [1:0] disp_src;
  logic       disp_valid;

  int n_chk;
  int n_err;
  int n_ack;
  int cyc;

  seg7_display_scheduler_if #(.NUM_REQ(NR)) bus ();

  seg7_display_scheduler #(
    .NUM_REQ(NR),
    .DWELL_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .disp_neg(disp_neg),
    .disp_dig0(disp_dig0),
    .disp_dig1(disp_dig1),
    .disp_dig2(disp_dig2),
    .disp_src(disp_src),
    .disp_valid(disp_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, int obs, int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int disp_now();
    return int'({disp_neg, disp_dig2, disp_dig1, disp_dig0,
                 disp_src, disp_valid});
  endfunction

  function automatic int ed(bit n, int d2, int d1, int d0, int s);
    return int'({n, 4'(d2), 4'(d1), 4'(d0), 2'(s), 1'b1});
  endfunction

  always @(negedge clk) begin
    if (bus.req_ack != '0) begin
      check("ack_onehot", $countones(bus.req_ack), 1);
      n_ack++;
    end
  end

  task automatic wait_ack(output int idx, output int t);
    bit got;
    got = 1'b0;
    idx = -1;
    t   = 0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (bus.req_ack != '0) begin
        got = 1'b1;
        idx = bus.req_ack[0] ? 0 : (bus.req_ack[1] ? 1 : 2);
        t   = cyc;
      end
    end
    if (!got) check("ack_timeout", 0, 1);
  endtask

  // Called at the negedge where the ack was seen (capture edge E0).
  task automatic commit_check(string tag, int prev, int exp);
    repeat (8) @(negedge clk);
    check({tag, "_pre"}, disp_now(), prev);
    @(negedge clk);
    check(tag, disp_now(), exp);
  endtask

  task automatic run_one(string tag, int r, logic [7:0] v, int prev, int exp);
    int idx;
    int t;
    bus.req_val[8*r +: 8] = v;
    bus.req_valid         = 3'b001 << r;
    wait_ack(idx, t);
    bus.req_valid = '0;
    check({tag, "_src"}, idx, r);
    commit_check(tag, prev, exp);
  endtask

  int idx;
  int t;
  int tprev;
  int a0;
  int exp_rr [4];
  int ord_rr [4];
  int ord_sk [3];

  initial begin
    n_chk = 0;
    n_err = 0;
    n_ack = 0;
    cyc   = 0;
    rst   = 1'b0;
    bus.req_valid = '0;
    bus.req_val   = '0;

    repeat (2) @(negedge clk);
    check("rst_disp", disp_now(), 0);
    check("rst_ack", int'(bus.req_ack), 0);

    rst = 1'b1;
    run_one("neg10", 0, 8'hF6, 0, ed(1, 0, 1, 0, 0));
    run_one("m128", 1, 8'h80, ed(1, 0, 1, 0, 0), ed(1, 1, 2, 8, 1));
    run_one("p127", 2, 8'h7F, ed(1, 1, 2, 8, 1), ed(0, 1, 2, 7, 2));
    run_one("zero", 0, 8'h00, ed(0, 1, 2, 7, 2), ed(0, 0, 0, 0, 0));

    // Abort a conversion in its 4th cycle.
    bus.req_val[15:8] = 8'h33;
    bus.req_valid     = 3'b010;
    wait_ack(idx, t);
    bus.req_valid = '0;
    check("abort_src", idx, 1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_disp", disp_now(), 0);
    check("abort_ack", int'(bus.req_ack), 0);

    bus.req_val   = {8'h64, 8'hFA, 8'h05};
    bus.req_valid = 3'b111;
    @(negedge clk);
    rst = 1'b1;

    exp_rr = '{ed(0, 0, 0, 5, 0), ed(1, 0, 0, 6, 1),
               ed(0, 1, 0, 0, 2), ed(0, 0, 0, 5, 0)};
    ord_rr = '{0, 1, 2, 0};
    tprev  = 0;
    for (int g = 0; g < 4; g++) begin
      wait_ack(idx, t);
      check("rr_grant", idx, ord_rr[g]);
      if (g > 0) check("rr_spacing", t - tprev, 14);
      tprev = t;
      commit_check("rr_disp", g == 0 ? 0 : exp_rr[g-1], exp_rr[g]);
    end

    bus.req_valid = '0;
    a0 = n_ack;
    repeat (40) @(negedge clk);
    check("hold_disp", disp_now(), ed(0, 0, 0, 5, 0));
    check("hold_noack", n_ack - a0, 0);
    run_one("late2", 2, 8'h2A, ed(0, 0, 0, 5, 0), ed(0, 0, 4, 2, 2));

    // Requester 1 drops out just before its turn and must be skipped.
    bus.req_val   = {8'h03, 8'h02, 8'h01};
    bus.req_valid = 3'b111;
    ord_sk = '{0, 2, 0};
    for (int g = 0; g < 3; g++) begin
      wait_ack(idx, t);
      check("skip_grant", idx, ord_sk[g]);
      if (g == 0) begin
        repeat (12) @(negedge clk);
        bus.req_valid = 3'b101;
      end
    end
    bus.req_valid = '0;
    commit_check("skip_disp", ed(0, 0, 0, 3, 2), ed(0, 0, 0, 1, 0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
